lsu_sram_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the single-cycle core datapath and a handshaked synchronous SRAM. It accepts one decoded memory request per instruction, using the control unit's `wr_en`, `ld_sel` and `bmask` fields. It stalls the core while it shifts byte lanes, drives the SRAM request and waits for the acknowledge. It then returns aligned, sign- or zero-extended load data for exactly one cycle.

---
 rtl/lsu_sram_ctrl_pkg.sv | 40 ++++
 rtl/lsu_sram_ctrl_if.sv | 22 ++
 rtl/lsu_sram_ctrl_load_align.sv | 26 ++
 rtl/lsu_sram_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_sram_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_sram_ctrl_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, load selectors,
// store byte-mask constants and the access-alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_sel_e;

  localparam logic [3:0] BMASK_B = 4'b0001;
  localparam logic [3:0] BMASK_H = 4'b0011;
  localparam logic [3:0] BMASK_W = 4'b1111;

  // Halfwords need an even address, words a 4-byte boundary; anything else is byte-sized.
  function automatic logic lsu_misaligned(input logic       wr,
                                          input logic [2:0] sel,
                                          input logic [3:0] bm,
                                          input logic [1:0] off);
    logic half_v;
    logic word_v;
    if (wr) begin
      half_v = (bm == BMASK_H);
      word_v = (bm == BMASK_W);
    end else begin
      half_v = (sel == LD_H) || (sel == LD_HU);
      word_v = (sel == LD_W);
    end
    return (half_v & off[0]) | (word_v & (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_sram_ctrl_if.sv
// Handshaked synchronous SRAM port: the controller is the master, the memory the slave.
interface lsu_sram_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              sram_ce;
  logic              sram_we;
  logic [3:0]        sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ready;

  modport master (
    output sram_ce, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready
  );

  modport slave (
    input  sram_ce, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_rdata, sram_ready
  );
endinterface

// File: rtl/lsu_sram_ctrl_load_align.sv
// Extracts and sign/zero-extends a byte, halfword or word from a 32-bit memory word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  ld_sel_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted_s;

  // Bring the addressed lane down to bit 0, then extend by load type.
  always_comb begin
    shifted_s = word_i >> {off_i, 3'b000};
    case (ld_sel_i)
      LD_B:    data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LD_BU:   data_o = {24'h000000, shifted_s[7:0]};
      LD_H:    data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LD_HU:   data_o = {16'h0000, shifted_s[15:0]};
      LD_W:    data_o = shifted_s;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Multi-cycle load/store sequencer: stalls the core, drives one SRAM request per
// memory instruction and returns the extended load result or an error strobe in RESP.
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_req,
  input  logic            wr_en,
  input  logic [2:0]      ld_sel,
  input  logic [3:0]      bmask,
  input  logic [31:0]     addr,
  input  logic [31:0]     st_data,
  output logic            stall,
  output logic [31:0]     ld_data,
  output logic            ld_vld,
  output logic            misalign_err,
  output logic            timeout_err,
  lsu_sram_ctrl_if.master sram
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic              wr_q;
  logic [2:0]        sel_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              misalign_q;
  logic              timeout_q;

  logic              misaligned_s;
  logic [31:0]       align_s;
  logic              load_ok_s;
  logic              unused_addr_s;

  assign misaligned_s  = lsu_misaligned(wr_en, ld_sel, bmask, addr[1:0]);
  assign unused_addr_s = ^addr[31:ADDR_W+2];

  lsu_load_align u_align (
    .word_i   (rdata_q),
    .off_i    (off_q),
    .ld_sel_i (sel_q),
    .data_o   (align_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a ready on the last allowed cycle still counts as success.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = misaligned_s ? RESP : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (sram.sram_ready || (cnt_q == CNT_LAST)) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counting and read-data latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      sel_q      <= 3'b000;
      off_q      <= 2'b00;
      waddr_q    <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            misalign_q <= misaligned_s;
            timeout_q  <= 1'b0;
            if (!misaligned_s) begin
              wr_q    <= wr_en;
              sel_q   <= ld_sel;
              off_q   <= addr[1:0];
              waddr_q <= addr[ADDR_W+1:2];
              be_q    <= wr_en ? (bmask << addr[1:0]) : BMASK_W;
              wdata_q <= st_data << {addr[1:0], 3'b000};
              cnt_q   <= '0;
            end
          end
        end
        ACCESS: begin
          if (sram.sram_ready) begin
            rdata_q <= sram.sram_rdata;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs: stall is gated by reset so the core is released while reset is held.
  always_comb begin
    load_ok_s       = (state_q == RESP) & ~wr_q & ~misalign_q & ~timeout_q;
    stall           = rst_n & (((state_q == IDLE) & mem_req) | (state_q == ACCESS));
    ld_vld          = load_ok_s;
    ld_data         = load_ok_s ? align_s : 32'h0000_0000;
    misalign_err    = (state_q == RESP) & misalign_q;
    timeout_err     = (state_q == RESP) & timeout_q;
    sram.sram_ce    = (state_q == ACCESS);
    sram.sram_we    = (state_q == ACCESS) & wr_q;
    sram.sram_be    = (state_q == ACCESS) ? be_q    : 4'b0000;
    sram.sram_addr  = (state_q == ACCESS) ? waddr_q : '0;
    sram.sram_wdata = (state_q == ACCESS) ? wdata_q : 32'h0000_0000;
  end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Self-checking bench for lsu_sram_ctrl: directed scenarios plus randomized
// transactions, each predicted from byte-lane arithmetic on the request fields.
module tb_lsu_sram_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        wr_en;
  logic [2:0]  ld_sel;
  logic [3:0]  bmask;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_vld;
  logic        misalign_err;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  lsu_sram_ctrl_if #(.ADDR_W(18)) sif ();

  lsu_sram_ctrl #(.ADDR_W(18), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .wr_en        (wr_en),
    .ld_sel       (ld_sel),
    .bmask        (bmask),
    .addr         (addr),
    .st_data      (st_data),
    .stall        (stall),
    .ld_data      (ld_data),
    .ld_vld       (ld_vld),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .sram         (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access size in bytes as the instruction encodes it.
  function automatic int acc_size(input logic wr, input logic [2:0] sel, input logic [3:0] bm);
    if (wr) begin
      if (bm == 4'b1111) return 4;
      if (bm == 4'b0011) return 2;
      return 1;
    end
    if (sel == 3'd2) return 4;
    if (sel == 3'd1 || sel == 3'd4) return 2;
    return 1;
  endfunction

  function automatic int byte_at(input logic [31:0] w, input int k);
    return int'(w[8*k +: 8]);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] sel, input logic [31:0] w, input int off);
    int v;
    case (sel)
      3'd0, 3'd3: begin
        v = byte_at(w, off);
        if (sel == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd4: begin
        v = byte_at(w, off) + 256 * byte_at(w, off + 1);
        if (sel == 3'd1 && v >= 32768) v = v - 65536;
      end
      3'd2:    return w;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // Lane j of the SRAM word carries byte (j - off) of the store.
  function automatic logic [3:0] exp_be(input logic [3:0] bm, input int off);
    logic [3:0] r = 4'b0000;
    for (int j = 0; j < 4; j++) if (j >= off) r[j] = bm[j-off];
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int off);
    logic [31:0] r = 32'h0;
    for (int j = 0; j < 4; j++) if (j >= off) r[8*j +: 8] = sd[8*(j-off) +: 8];
    return r;
  endfunction

  // One memory instruction from its first IDLE cycle through RESP; ends one cycle later.
  task automatic run_txn(input string nm, input logic wr, input logic [2:0] sel,
                         input logic [3:0] bm, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] rd);
    int off, n_acc, n_stall, first_ce, cyc, e_acc;
    bit mis, to, done, ok_ld;
    logic [3:0]  ebe;
    logic [31:0] ewd, eld, eaddr;
    off   = int'(a[1:0]);
    mis   = (off % acc_size(wr, sel, bm)) != 0;
    to    = !mis && (waits >= TO);
    ok_ld = !wr && !mis && !to;
    e_acc = mis ? 0 : (to ? TO : waits + 1);
    ebe   = wr ? exp_be(bm, off) : 4'b1111;
    ewd   = exp_wdata(sd, off);
    eld   = ok_ld ? exp_load(sel, rd, off) : 32'h0;
    eaddr = (a >> 2) & 32'h0003_FFFF;
    mem_req = 1'b1; wr_en = wr; ld_sel = sel; bmask = bm; addr = a; st_data = sd;
    sif.sram_ready = 1'($urandom);
    sif.sram_rdata = $urandom;
    n_acc = 0; n_stall = 0; first_ce = -1; cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      #1;
      if (sif.sram_ce === 1'b1) begin
        n_acc++;
        if (first_ce < 0) first_ce = cyc;
        chk({nm, ".we"},    32'(sif.sram_we), 32'(wr));
        chk({nm, ".be"},    32'(sif.sram_be), 32'(ebe));
        chk({nm, ".addr"},  32'(sif.sram_addr), eaddr);
        chk({nm, ".wdata"}, sif.sram_wdata, ewd);
      end
      if (stall === 1'b1) begin
        n_stall++;
        chk({nm, ".quiet"}, {29'd0, ld_vld, misalign_err, timeout_err}, 32'd0);
        chk({nm, ".ld_data_idle"}, ld_data, 32'h0);
        sif.sram_ready = (sif.sram_ce === 1'b1) ? (n_acc > waits) : 1'($urandom);
        sif.sram_rdata = sif.sram_ready ? rd : $urandom;
        @(posedge clk); #1;
        cyc++;
      end else begin
        done = 1;
        chk({nm, ".ld_vld"},   32'(ld_vld), 32'(ok_ld));
        chk({nm, ".misalign"}, 32'(misalign_err), 32'(mis));
        chk({nm, ".timeout"},  32'(timeout_err), 32'(to));
        chk({nm, ".ld_data"},  ld_data, eld);
      end
    end
    chk({nm, ".finished"},   32'(done), 32'd1);
    chk({nm, ".acc_cycles"}, 32'(n_acc), 32'(e_acc));
    chk({nm, ".stall_cyc"},  32'(n_stall), 32'(e_acc + 1));
    if (!mis) chk({nm, ".ce_start"}, 32'(first_ce), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mem_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      addr = $urandom; st_data = $urandom;
      sif.sram_ready = 1'($urandom); sif.sram_rdata = $urandom;
      #1;
      chk("idle.outs", {27'd0, stall, sif.sram_ce, ld_vld, misalign_err, timeout_err}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [2:0]  r_sel;
    logic [3:0]  r_bm;
    rst_n = 1'b0; mem_req = 1'b1; wr_en = 1'b0; ld_sel = 3'd2; bmask = 4'b1111;
    addr = 32'h0; st_data = 32'h0; sif.sram_ready = 1'b1; sif.sram_rdata = 32'h0;
    #3;
    chk("reset.outs", {27'd0, stall, sif.sram_ce, ld_vld, misalign_err, timeout_err}, 32'd0);
    chk("reset.ld_data", ld_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_txn("lb_sext", 1'b0, 3'd0, 4'b0001, 32'h0000_0103, 32'h0, 0, 32'h80FF_0000);
    run_txn("sh_wait", 1'b1, 3'd0, 4'b0011, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h5555_AAAA);
    idle(1);
    run_txn("lw_mis", 1'b0, 3'd2, 4'b1111, 32'h0000_0006, 32'h0, 0, 32'hDEAD_BEEF);
    run_txn("lhu_to", 1'b0, 3'd4, 4'b0011, 32'h0000_0002, 32'h0, 99, 32'h1234_5678);
    idle(1);

    // Reset in the middle of an access must drop the request and stall at once.
    mem_req = 1'b1; wr_en = 1'b0; ld_sel = 3'd2; bmask = 4'b1111; addr = 32'h20;
    sif.sram_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.ce_before", 32'(sif.sram_ce), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ce", 32'(sif.sram_ce), 32'd0);
    chk("rst_mid.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn("lw_after_rst", 1'b0, 3'd2, 4'b1111, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D);

    run_txn("b2b_lw", 1'b0, 3'd2, 4'b1111, 32'h0000_0040, 32'h0, 0, 32'h0102_0304);
    run_txn("b2b_sw", 1'b1, 3'd0, 4'b1111, 32'h0000_0044, 32'hA5A5_5A5A, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      r_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 2))
        0:       r_bm = 4'b0001;
        1:       r_bm = 4'b0011;
        default: r_bm = 4'b1111;
      endcase
      run_txn("rand", 1'($urandom), r_sel, r_bm, $urandom, $urandom,
              int'($urandom_range(0, 5)), $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
